// File: rtl/inst_fetch_responder_if.sv
// Instruction-fetch handshake bundle: inst_addr/inst_line channels toward the core
// and the single-beat AR/R read channels toward instruction memory.
interface inst_fetch_responder_if;
  logic        inst_addr_valid;
  logic        inst_addr_ready;
  logic [31:0] inst_addr;
  logic        inst_line_valid;
  logic        inst_line_ready;
  logic [31:0] inst_line;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;

  // Responder side (the fetch responder itself)
  modport slave (
    input  inst_addr_valid, inst_addr, inst_line_ready,
           mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    output inst_addr_ready, inst_line_valid, inst_line,
           mem_arvalid, mem_araddr, mem_rready
  );

  // Environment side: core front end plus instruction memory
  modport master (
    output inst_addr_valid, inst_addr, inst_line_ready,
           mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    input  inst_addr_ready, inst_line_valid, inst_line,
           mem_arvalid, mem_araddr, mem_rready
  );
endinterface

// File: rtl/inst_fetch_responder.sv
// Instruction-fetch responder: in-order fetch address -> instruction word, with
// misaligned requests answered locally and aligned ones sent as single-beat reads.
module inst_fetch_responder #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] ERR_INST        = 32'h0000_0000,
  parameter int unsigned ERRCNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  inst_fetch_responder_if.slave   bus,
  output logic [ERRCNT_WIDTH-1:0] err_count
);

  localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned PW = AW + 1;

  // Order queue: one "misaligned" flag per accepted request
  logic          oq_mis [MAX_OUTSTANDING];
  logic [PW-1:0] oq_wp, oq_rp;
  logic          oq_empty, oq_full, oq_head_mis;

  // Response FIFO: returned read beats awaiting their turn at the OQ head
  logic          rf_err  [MAX_OUTSTANDING];
  logic [31:0]   rf_data [MAX_OUTSTANDING];
  logic [PW-1:0] rf_wp, rf_rp;
  logic          rf_empty;

  logic          arvalid_q;
  logic [31:0]   araddr_q;
  logic [PW-1:0] mem_outstanding;
  logic [ERRCNT_WIDTH-1:0] err_q;

  logic addr_ready, addr_hs, addr_mis;
  logic line_valid, line_hs, rf_pop;
  logic ar_hs, r_hs, rready, r_err;

  always_comb begin
    oq_empty    = (oq_wp == oq_rp);
    oq_full     = (oq_wp[AW] != oq_rp[AW]) && (oq_wp[AW-1:0] == oq_rp[AW-1:0]);
    rf_empty    = (rf_wp == rf_rp);
    oq_head_mis = oq_mis[oq_rp[AW-1:0]];

    addr_mis   = |bus.inst_addr[1:0];
    // A draining AR slot frees itself this cycle, so a new address may load it directly
    addr_ready = rst & ~oq_full & (~arvalid_q | bus.mem_arready);
    addr_hs    = bus.inst_addr_valid & addr_ready;

    line_valid = rst & ~oq_empty & (oq_head_mis | ~rf_empty);
    line_hs    = line_valid & bus.inst_line_ready;
    rf_pop     = line_hs & ~oq_head_mis;

    ar_hs  = rst & arvalid_q & bus.mem_arready;
    rready = rst & (mem_outstanding != '0);
    r_hs   = bus.mem_rvalid & rready;
    r_err  = (bus.mem_rresp != 2'b00);
  end

  always_comb begin
    bus.inst_addr_ready = addr_ready;
    bus.inst_line_valid = line_valid;
    bus.mem_arvalid     = rst & arvalid_q;
    bus.mem_araddr      = rst ? araddr_q : '0;
    bus.mem_rready      = rready;
    err_count           = rst ? err_q : '0;
    if (!line_valid || oq_head_mis || rf_err[rf_rp[AW-1:0]]) begin
      bus.inst_line = ERR_INST;
    end else begin
      bus.inst_line = rf_data[rf_rp[AW-1:0]];
    end
  end

  // Queue storage carries no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (addr_hs) begin
      oq_mis[oq_wp[AW-1:0]] <= addr_mis;
    end
    if (r_hs) begin
      rf_err[rf_wp[AW-1:0]]  <= r_err;
      rf_data[rf_wp[AW-1:0]] <= bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      oq_wp           <= '0;
      oq_rp           <= '0;
      rf_wp           <= '0;
      rf_rp           <= '0;
      arvalid_q       <= 1'b0;
      araddr_q        <= '0;
      mem_outstanding <= '0;
      err_q           <= '0;
    end else begin
      if (addr_hs) begin
        oq_wp <= oq_wp + PW'(1);
      end
      if (line_hs) begin
        oq_rp <= oq_rp + PW'(1);
      end
      if (r_hs) begin
        rf_wp <= rf_wp + PW'(1);
      end
      if (rf_pop) begin
        rf_rp <= rf_rp + PW'(1);
      end

      if (addr_hs && !addr_mis) begin
        arvalid_q <= 1'b1;
        araddr_q  <= {bus.inst_addr[31:2], 2'b00};
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
      end

      unique case ({ar_hs, r_hs})
        2'b10:   mem_outstanding <= mem_outstanding + PW'(1);
        2'b01:   mem_outstanding <= mem_outstanding - PW'(1);
        default: mem_outstanding <= mem_outstanding;
      endcase

      if (r_hs && r_err && (err_q != '1)) begin
        err_q <= err_q + ERRCNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Self-checking bench for inst_fetch_responder: directed scenarios plus a randomized
// phase, all checked cycle by cycle against an in-order queue model.
module tb_inst_fetch_responder;
  localparam int unsigned MAXO = 4;
  localparam logic [31:0] ERRW = 32'hDEAD_0BAD;
  localparam int unsigned ECW  = 8;
  localparam logic [31:0] XK   = 32'hA5A5_A5A5;

  typedef struct { logic [31:0] data; logic [1:0] resp; int due; } beat_t;
  typedef struct { logic err; logic [31:0] data; } ret_t;

  logic clk = 1'b0;
  logic rst;
  logic [ECW-1:0] err_count;

  inst_fetch_responder_if ifc();

  inst_fetch_responder #(.MAX_OUTSTANDING(MAXO), .ERR_INST(ERRW), .ERRCNT_WIDTH(ECW)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  logic        req_mis[$];
  ret_t        ret_q[$];
  beat_t       pend[$];
  logic [31:0] to_send[$];
  logic [31:0] got_ar[$];
  logic [31:0] got_lines[$];
  bit          slot_busy = 0;
  logic [31:0] slot_addr = '0;
  int          err_model = 0;
  bit a_taken = 0, r_taken = 0;
  bit mem_hold = 0, ar_random = 0, lr_random = 0, gap_random = 0;
  bit err_mode = 0, err_all = 0, err_rand = 0, stray = 0;
  bit l_ready_fixed = 1;
  int lat_min = 2, lat_max = 2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, got, exp);
  endtask

  task automatic cycle();
    logic        exp_valid, exp_ardy, a_hs, l_hs, ar_hs, r_hs, mis;
    logic [31:0] exp_line;
    beat_t       b;
    ret_t        r;
    if (r_taken) begin ifc.mem_rvalid = 1'b0; r_taken = 0; end
    if (a_taken) begin ifc.inst_addr_valid = 1'b0; a_taken = 0; end
    if (rst === 1'b0) begin
      ifc.inst_addr_valid = 1'b0;
      ifc.mem_rvalid      = 1'b0;
      #1;
      chk("rst_addr_ready", ifc.inst_addr_ready, 0);
      chk("rst_line_valid", ifc.inst_line_valid, 0);
      chk("rst_arvalid", ifc.mem_arvalid, 0);
      chk("rst_rready", ifc.mem_rready, 0);
      chk("rst_araddr", ifc.mem_araddr, 0);
      chk("rst_line", ifc.inst_line, ERRW);
      chk("rst_err_count", err_count, 0);
      req_mis.delete(); ret_q.delete(); pend.delete(); to_send.delete();
      slot_busy = 0; err_model = 0;
      @(posedge clk); @(negedge clk); cyc++;
      return;
    end
    if (!ifc.inst_addr_valid && to_send.size() > 0 && !(gap_random && $urandom_range(0, 2) == 0)) begin
      ifc.inst_addr_valid = 1'b1;
      ifc.inst_addr       = to_send[0];
    end
    ifc.inst_line_ready = lr_random ? 1'($urandom_range(0, 1)) : l_ready_fixed;
    ifc.mem_arready     = ar_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (stray) begin
      ifc.mem_rvalid = 1'b1; ifc.mem_rdata = 32'hBAD0_BAD0; ifc.mem_rresp = 2'b01;
    end else if (!ifc.mem_rvalid && !mem_hold && pend.size() > 0 && pend[0].due <= cyc) begin
      ifc.mem_rvalid = 1'b1; ifc.mem_rdata = pend[0].data; ifc.mem_rresp = pend[0].resp;
    end
    #1;
    exp_valid = (req_mis.size() > 0) && (req_mis[0] || ret_q.size() > 0);
    exp_line  = ERRW;
    if (exp_valid && !req_mis[0] && !ret_q[0].err) exp_line = ret_q[0].data;
    exp_ardy  = (req_mis.size() < MAXO) && (!slot_busy || ifc.mem_arready);
    chk("line_valid", ifc.inst_line_valid, exp_valid);
    if (exp_valid) chk("line", ifc.inst_line, exp_line);
    chk("addr_ready", ifc.inst_addr_ready, exp_ardy);
    chk("arvalid", ifc.mem_arvalid, slot_busy);
    if (slot_busy) chk("araddr", ifc.mem_araddr, slot_addr);
    chk("rready", ifc.mem_rready, pend.size() != 0);
    chk("err_count", err_count, err_model);

    a_hs  = ifc.inst_addr_valid && exp_ardy;
    l_hs  = exp_valid && ifc.inst_line_ready;
    ar_hs = slot_busy && ifc.mem_arready;
    r_hs  = ifc.mem_rvalid && (pend.size() != 0);
    if (r_hs) begin
      r.err = (ifc.mem_rresp != 2'b00); r.data = ifc.mem_rdata;
      ret_q.push_back(r);
      void'(pend.pop_front());
      if (r.err && err_model < (1 << ECW) - 1) err_model++;
      r_taken = 1;
    end
    if (ar_hs) begin
      b.resp = (err_mode || err_all || (err_rand && $urandom_range(0, 7) == 0)) ? 2'b10 : 2'b00;
      b.data = err_mode ? 32'h1234_5678 : (slot_addr ^ XK);
      b.due  = cyc + int'($urandom_range(lat_min, lat_max));
      pend.push_back(b);
      got_ar.push_back(slot_addr);
      slot_busy = 0;
    end
    if (l_hs) begin
      got_lines.push_back(exp_line);
      if (!req_mis[0]) void'(ret_q.pop_front());
      void'(req_mis.pop_front());
    end
    if (a_hs) begin
      mis = |ifc.inst_addr[1:0];
      req_mis.push_back(mis);
      if (!mis) begin slot_busy = 1; slot_addr = {ifc.inst_addr[31:2], 2'b00}; end
      void'(to_send.pop_front());
      a_taken = 1;
    end
    @(posedge clk); @(negedge clk); cyc++;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while ((to_send.size() > 0 || req_mis.size() > 0 || pend.size() > 0 || slot_busy) && k < bound) begin
      cycle();
      k++;
    end
    chk("drain_timeout", k < bound, 1);
  endtask

  initial begin
    logic [31:0] exp_lines[$];
    ifc.inst_addr_valid = 0; ifc.inst_addr = '0; ifc.inst_line_ready = 0;
    ifc.mem_arready = 0; ifc.mem_rvalid = 0; ifc.mem_rdata = '0; ifc.mem_rresp = '0;
    rst = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;

    // Stray read beat with nothing outstanding must be ignored
    stray = 1; repeat (2) cycle(); stray = 0; ifc.mem_rvalid = 1'b0; cycle();

    // Streaming
    got_lines.delete();
    to_send = '{32'h1000, 32'h1004, 32'h1008};
    drain(100);
    exp_lines = '{32'hA5A5_B5A5, 32'hA5A5_B5A1, 32'hA5A5_B5AD};
    chk("stream_count", got_lines.size(), 3);
    foreach (exp_lines[i]) chk("stream_line", got_lines[i], exp_lines[i]);

    // Full OQ with no read data returning
    mem_hold = 1;
    to_send = '{32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h4010};
    repeat (8) cycle();
    chk("full_ready_low", ifc.inst_addr_ready, 0);
    mem_hold = 0;
    drain(100);

    // Misaligned interleave, consumer stalled so later data arrives before the first line leaves
    got_ar.delete(); got_lines.delete();
    l_ready_fixed = 0; lat_min = 1; lat_max = 1;
    to_send = '{32'h2000, 32'h2002, 32'h2004};
    repeat (10) cycle();
    l_ready_fixed = 1;
    drain(100);
    chk("mis_ar_count", got_ar.size(), 2);
    chk("mis_ar0", got_ar[0], 32'h2000);
    chk("mis_ar1", got_ar[1], 32'h2004);
    chk("mis_line0", got_lines[0], 32'h2000 ^ XK);
    chk("mis_line1", got_lines[1], ERRW);
    chk("mis_line2", got_lines[2], 32'h2004 ^ XK);

    // Bus error
    got_lines.delete(); err_mode = 1;
    to_send = '{32'h5000};
    drain(100);
    err_mode = 0;
    chk("berr_line", got_lines[0], ERRW);
    chk("berr_count", err_count, 1);

    // Error counter saturation
    err_all = 1;
    for (int unsigned i = 0; i < (1 << ECW); i++) to_send.push_back(32'h8000 + 4 * i);
    drain(3000);
    err_all = 0;
    chk("sat_count", err_count, {ECW{1'b1}});

    // Backpressure
    got_lines.delete(); l_ready_fixed = 0;
    to_send = '{32'h6000, 32'h6004};
    repeat (10) cycle();
    chk("bp_valid_held", ifc.inst_line_valid, 1);
    l_ready_fixed = 1;
    drain(100);
    chk("bp_count", got_lines.size(), 2);
    chk("bp_line0", got_lines[0], 32'h6000 ^ XK);
    chk("bp_line1", got_lines[1], 32'h6004 ^ XK);

    // Randomized traffic
    ar_random = 1; lr_random = 1; gap_random = 1; err_rand = 1; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 80; i++) to_send.push_back($urandom);
    drain(2000);
    ar_random = 0; lr_random = 0; gap_random = 0; err_rand = 0; lat_min = 2; lat_max = 2;

    // Reset mid-flight
    mem_hold = 1;
    to_send = '{32'h7000, 32'h7004, 32'h7008};
    repeat (6) cycle();
    rst = 1'b0; cycle(); rst = 1'b1;
    mem_hold = 0;
    got_lines.delete(); got_ar.delete();
    to_send = '{32'h3000};
    drain(100);
    chk("rstmid_ar_count", got_ar.size(), 1);
    chk("rstmid_ar", got_ar[0], 32'h3000);
    chk("rstmid_count", got_lines.size(), 1);
    chk("rstmid_line", got_lines[0], 32'h3000 ^ XK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/inst_fetch_responder.md
Name: inst_fetch_responder

Overview:
- Responder end of the instruction-fetch address/line handshake. Accepts fetch addresses on the inst_addr channel and returns one 32-bit instruction word per address on the inst_line channel, strictly in request order.
- Sits between the core front end and the instruction memory port. Converts requests into read transactions on a single-beat read bus (AR/R style) with a bounded number outstanding.

Parameters:
- MAX_OUTSTANDING, 4, max accepted-but-unreturned requests; power of 2, range 2..16
- ERR_INST, 32'h0000_0000, word returned for bus-error or misaligned requests
- ERRCNT_WIDTH, 16, width of the saturating bus-error counter

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous reset, active-low (0 = reset)
- inst_addr_valid  in  1  fetch address valid
- inst_addr_ready  out  1  responder accepts address
- inst_addr  in  32  fetch byte address
- inst_line_valid  out  1  instruction word valid
- inst_line_ready  in  1  consumer accepts word
- inst_line  out  32  instruction word
- mem_arvalid  out  1  read request valid
- mem_arready  in  1  memory accepts request
- mem_araddr  out  32  word-aligned read address
- mem_rvalid  in  1  read data valid
- mem_rready  out  1  responder accepts read data
- mem_rdata  in  32  read data
- mem_rresp  in  2  2'b00 OK, otherwise bus error
- err_count  out  ERRCNT_WIDTH  saturating count of error beats

Behaviour:
- Handshakes: transfer happens when valid & ready on the same posedge. Valid, once raised, holds with stable payload until accepted, on every channel.
- Order queue (OQ): depth MAX_OUTSTANDING, 1 bit per entry (mis = |inst_addr[1:0]).
  - Push on inst_addr handshake.
  - Pop on inst_line handshake.
- AR register: one-entry request slot driving mem_arvalid/mem_araddr.
  - An accepted aligned address loads the slot; mem_arvalid = 1 from the next cycle until mem_arready.
  - mem_araddr = {addr[31:2], 2'b00}.
  - Misaligned addresses never reach the memory bus.
- inst_addr_ready = rst & ~OQ_full & (~arvalid_q | mem_arready). When the slot is draining on the same cycle, a new address is accepted and loads the slot directly. No bubble, so sustained throughput is 1 request/cycle.
- Response FIFO (RF): depth MAX_OUTSTANDING, entries {err, data}.
  - Written on mem_rvalid & mem_rready.
  - mem_rready = rst & (mem_outstanding != 0). mem_outstanding counts AR handshakes minus R handshakes.
  - A beat arriving while mem_outstanding == 0 is ignored.
  - RF never overflows, because mem_outstanding ≤ OQ occupancy ≤ MAX_OUTSTANDING.
- Return path:
  - inst_line_valid = ~OQ_empty & (OQ_head.mis | ~RF_empty).
  - inst_line = OQ_head.mis ? ERR_INST : (RF_head.err ? ERR_INST : RF_head.data).
  - RF pops together with OQ when the head is aligned.
- Latency: address accepted cycle 0, mem_arvalid cycle 1. For an R beat accepted in cycle N, inst_line_valid is asserted in cycle N+1 (RF is registered, no bypass). For a misaligned request at the OQ head, inst_line_valid is asserted the cycle after acceptance.
- Backpressure: inst_line_ready low stalls the OQ/RF heads. New addresses are accepted only until OQ is full.
- Simultaneous push and pop on a full OQ is allowed: addr_ready uses the pre-pop full flag, and occupancy is unchanged.
- Pointer wrap: pointers are log2(MAX_OUTSTANDING)+1 bits. Full = MSBs differ and the rest are equal.
- err_count increments on each R handshake with mem_rresp != 0. It saturates at all-ones and never wraps.
- Reset (rst = 0 sampled on a posedge) clears OQ, RF, AR slot, mem_outstanding and err_count. This applies mid-operation too: in-flight requests are forgotten, and the memory side must be reset in the same cycle.
- Output values during reset: inst_addr_ready = 0, inst_line_valid = 0, mem_arvalid = 0, mem_rready = 0, mem_araddr = 0, inst_line = ERR_INST, err_count = 0.

Test Plan:
- Streaming:
  - Stimulus: addresses 0x1000, 0x1004, 0x1008 back-to-back, mem_arready = 1, mem returns rdata = addr ^ 0xA5A5A5A5 two cycles after each AR, inst_line_ready = 1.
  - Required: inst_addr_ready stays 1; lines 0xA5A5B5A5, 0xA5A5B5A1, 0xA5A5B5AD in order, each one cycle after its R beat.
- Full OQ:
  - Stimulus: MAX_OUTSTANDING = 4, mem_rvalid held 0.
  - Required: after 4 accepted addresses, inst_addr_ready = 0. One R beat followed by its line handshake re-raises ready within 1 cycle.
- Misaligned interleave:
  - Stimulus: 0x2000, 0x2002, 0x2004.
  - Required: only 0x2000 and 0x2004 appear on mem_araddr; lines return data(0x2000), ERR_INST, data(0x2004) in that order, even if data(0x2004) arrives before 0x2000 is returned.
- Bus error:
  - Stimulus: R beat with mem_rresp = 2'b10, rdata = 0x12345678.
  - Required: inst_line = ERR_INST, err_count = 1. Force err_count to all-ones via 65535 errors, then one more error: err_count stays 0xFFFF.
- Backpressure:
  - Stimulus: inst_line_ready = 0 for 10 cycles with 2 lines ready.
  - Required: inst_line_valid held, inst_line stable, no word lost. Both words delivered in order after ready rises.
- Reset mid-flight:
  - Stimulus: rst = 0 for 1 cycle with 3 requests outstanding.
  - Required: all outputs at reset values the next cycle; subsequent address 0x3000 returns only data(0x3000).
